// File: rtl/pipe_store_buf_pkg.sv
// Shared definitions for the store buffer: drain FSM encoding, lane masks,
// and the per-lane merge used by read-modify-write.
package pipe_store_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_MERGE = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  localparam logic [3:0] MASK_W   = 4'b1111;
  localparam logic [3:0] MASK_HLO = 4'b0011;
  localparam logic [3:0] MASK_HHI = 4'b1100;

  // Per byte lane: take the new data where the mask is set, else keep old.
  function automatic logic [31:0] lane_merge(input logic [3:0]  mask,
                                             input logic [31:0] new_d,
                                             input logic [31:0] old_d);
    logic [31:0] r;
    r = old_d;
    for (int l = 0; l < 4; l++) begin
      if (mask[l]) r[8*l +: 8] = new_d[8*l +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_store_buf_align.sv
// Size/alignment decode for a memory access: lane mask, lane-replicated data
// and the misalignment flag. Purely combinational, usable by the load path too.
module store_align
  import pipe_store_buf_pkg::*;
(
  input  logic        w,
  input  logic        h,
  input  logic        b,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [3:0]  mask,
  output logic [31:0] rep_data,
  output logic        addr_err
);

  // Decode size selects with priority word > half > byte.
  always_comb begin
    mask     = 4'b0000;
    rep_data = 32'h0;
    addr_err = ~((w & (addr_lo == 2'b00)) | (h & ~addr_lo[0]) | b);
    if (w) begin
      mask     = MASK_W;
      rep_data = data;
    end else if (h) begin
      mask     = addr_lo[1] ? MASK_HHI : MASK_HLO;
      rep_data = {2{data[15:0]}};
    end else if (b) begin
      mask     = 4'b0001 << addr_lo;
      rep_data = {4{data[7:0]}};
    end
  end

endmodule

// File: rtl/pipe_store_buf.sv
// Store buffer: queues aligned stores in a small circular FIFO and drains them
// into a word-wide RAM without byte enables, using read-modify-write for
// sub-word stores. Flags loads that hit a pending store word.
//
// Handshake: a store is taken on a cycle where st_valid & st_ready & ~AddressErr;
// st_ready depends only on the current fill level, so a full queue never
// accepts even if it pops in the same cycle. Rejected requests are dropped and
// the producer is expected to hold/retry while st_ready is low.
module pipe_store_buf
  import pipe_store_buf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w,
  input  logic              h,
  input  logic              b,
  input  logic              st_valid,
  input  logic [31:0]       addr,
  input  logic [31:0]       st_data,
  output logic              st_ready,
  output logic              AddressErr,
  input  logic              ld_valid,
  input  logic [31:0]       ld_addr,
  output logic              ld_hazard,
  output logic              drain_active,
  output logic              empty,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Queue storage and bookkeeping
  logic [ADDR_W-1:0] r_q_addr [DEPTH];
  logic [3:0]        r_q_mask [DEPTH];
  logic [31:0]       r_q_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_merged;

  logic [3:0]        w_in_mask;
  logic [31:0]       w_in_data;
  logic [ADDR_W-1:0] w_in_addr;
  logic              w_full;
  logic              w_enq;
  logic              w_deq;
  logic              w_start;
  logic [3:0]        w_start_mask;
  logic [ADDR_W-1:0] w_head_addr;
  logic [3:0]        w_head_mask;
  logic [31:0]       w_head_data;
  logic              w_hit;
  logic              w_unused;

  assign w_unused = ^{addr[31:ADDR_W+2], ld_addr[31:ADDR_W+2], ld_addr[1:0]};

  store_align u_align (
    .w        (w),
    .h        (h),
    .b        (b),
    .addr_lo  (addr[1:0]),
    .data     (st_data),
    .mask     (w_in_mask),
    .rep_data (w_in_data),
    .addr_err (AddressErr)
  );

  assign w_in_addr   = addr[ADDR_W+1:2];
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign st_ready    = ~w_full;
  assign w_enq       = st_valid & st_ready & ~AddressErr;
  assign w_deq       = (r_state == ST_WRITE);
  assign w_head_addr = r_q_addr[r_rd_ptr];
  assign w_head_mask = r_q_mask[r_rd_ptr];
  assign w_head_data = r_q_data[r_rd_ptr];
  assign empty       = (r_count == '0) & (r_state == ST_IDLE);
  assign dbg_state   = r_state;

  // When the queue is empty, the store being enqueued now becomes the head
  // next cycle, so IDLE decides on its mask directly to save a cycle.
  assign w_start      = (r_count != '0) | w_enq;
  assign w_start_mask = (r_count != '0) ? w_head_mask : w_in_mask;

  // Write the incoming entry at the tail.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_addr[r_wr_ptr] <= w_in_addr;
      r_q_mask[r_wr_ptr] <= w_in_mask;
      r_q_data[r_wr_ptr] <= w_in_data;
    end
  end

  // Pointer and fill-level tracking; simultaneous push/pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Drain FSM next state: full words write directly, partial words go via RMW.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = (w_start_mask == MASK_W) ? ST_WRITE : ST_READ;
      ST_READ:  w_state_nxt = ST_MERGE;
      ST_MERGE: w_state_nxt = ST_WRITE;
      ST_WRITE: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // RAM port drive; address/data are held at zero when the port is idle.
  always_comb begin
    ram_ena      = 1'b0;
    ram_wena     = 1'b0;
    ram_addr     = '0;
    ram_wdata    = 32'h0;
    drain_active = 1'b0;
    case (r_state)
      ST_READ: begin
        ram_ena      = 1'b1;
        ram_addr     = w_head_addr;
        drain_active = 1'b1;
      end
      ST_MERGE: drain_active = 1'b1;
      ST_WRITE: begin
        ram_ena      = 1'b1;
        ram_wena     = 1'b1;
        ram_addr     = w_head_addr;
        ram_wdata    = (w_head_mask == MASK_W) ? w_head_data : r_merged;
        drain_active = 1'b1;
      end
      default: ;
    endcase
  end

  // Capture the merged word while the read data is on ram_rdata.
  always_ff @(posedge clk) begin
    if (rst)                     r_merged <= 32'h0;
    else if (r_state == ST_MERGE) r_merged <= lane_merge(w_head_mask, w_head_data, ram_rdata);
  end

  // Load hazard: compare the load word against every occupied queue slot.
  always_comb begin
    logic [PTR_W-1:0] v_off;
    v_off = '0;
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      v_off = PTR_W'(i) - r_rd_ptr;
      if (({1'b0, v_off} < r_count) && (r_q_addr[i] == ld_addr[ADDR_W+1:2])) w_hit = 1'b1;
    end
  end

  assign ld_hazard = ld_valid & w_hit;

endmodule

// File: tb/tb_pipe_store_buf.sv
// Bench for pipe_store_buf: a behavioural RAM, a reference model of memory
// contents plus the ordered list of pending stores, directed scenarios and a
// randomized phase.
module tb_pipe_store_buf;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;
  localparam int NW     = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              w, h, b, st_valid, st_ready, AddressErr;
  logic [31:0]       st_addr, st_data;
  logic              ld_valid, ld_hazard, drain_active, empty;
  logic [31:0]       ld_addr;
  logic              ram_ena, ram_wena;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;
  logic [1:0]        dbg_state;

  pipe_store_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .w(w), .h(h), .b(b), .st_valid(st_valid),
    .addr(st_addr), .st_data(st_data), .st_ready(st_ready), .AddressErr(AddressErr),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .drain_active(drain_active), .empty(empty), .ram_ena(ram_ena), .ram_wena(ram_wena),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // ---------------- RAM environment ----------------
  logic [31:0] mem [NW];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_ena && ram_wena) mem[ram_addr] <= ram_wdata;
    if (ram_ena && !ram_wena) ram_rdata <= mem[ram_addr];
  end

  // ---------------- scoreboard / model ----------------
  // entry = {word addr[7:0], value to be written[31:0], value before[31:0]}
  logic [71:0] exp_q[$];
  logic [31:0] model_mem [NW];
  int n_checks = 0;
  int n_fail   = 0;

  logic        s_ena, s_wena, s_drain, s_hz, s_empty, s_ready, s_err, s_acc;
  logic [7:0]  s_addr;
  logic [31:0] s_wdata;
  logic [1:0]  s_state;
  logic        saw_full;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] apply_store(input logic [31:0] old, input logic ww,
                                              input logic hh, input logic [31:0] a,
                                              input logic [31:0] d);
    logic [31:0] r;
    r = old;
    if (ww)      r = d;
    else if (hh) r[16*int'(a[1]) +: 16] = d[15:0];
    else         r[8*int'(a[1:0]) +: 8] = d[7:0];
    return r;
  endfunction

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    logic        exp_err, exp_hz, wrote, acc;
    logic [7:0]  wa;
    logic [31:0] ov, nv;
    logic [71:0] e;
    @(negedge clk);
    exp_err = !((w && st_addr[1:0] == 2'b00) || (h && !st_addr[0]) || b);
    chk("addr_err", AddressErr, exp_err);
    chk("st_ready", st_ready, exp_q.size() < DEPTH);
    chk("empty", empty, exp_q.size() == 0);
    exp_hz = 1'b0;
    foreach (exp_q[i]) if (exp_q[i][71:64] == ld_addr[9:2]) exp_hz = 1'b1;
    chk("ld_hazard", ld_hazard, exp_hz & ld_valid);
    wrote = ram_ena && ram_wena;
    if (wrote) begin
      chk("write_has_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        chk("wr_addr", ram_addr, exp_q[0][71:64]);
        chk("wr_data", ram_wdata, exp_q[0][63:32]);
      end
    end
    if (!ram_ena) begin
      chk("idle_wena", ram_wena, 0);
      chk("idle_addr", ram_addr, 0);
      chk("idle_wdata", ram_wdata, 0);
    end
    if (saw_full == 1'b0 && st_ready == 1'b0) saw_full = 1'b1;
    s_ena = ram_ena; s_wena = ram_wena; s_addr = ram_addr; s_wdata = ram_wdata;
    s_drain = drain_active; s_hz = ld_hazard; s_empty = empty; s_ready = st_ready;
    s_err = AddressErr; s_state = dbg_state;
    acc = st_valid && (exp_q.size() < DEPTH) && !exp_err && !rst;
    s_acc = acc;
    @(posedge clk);
    if (wrote && exp_q.size() != 0) void'(exp_q.pop_front());
    if (rst) begin
      while (exp_q.size() != 0) begin
        e = exp_q.pop_back();
        model_mem[e[71:64]] = e[31:0];
      end
    end else if (acc) begin
      wa = st_addr[9:2];
      ov = model_mem[wa];
      nv = apply_store(ov, w, h, st_addr, st_data);
      model_mem[wa] = nv;
      exp_q.push_back({wa, nv, ov});
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_store(input logic ww, input logic hh, input logic bb,
                           input logic [31:0] a, input logic [31:0] d);
    w = ww; h = hh; b = bb; st_addr = a; st_data = d; st_valid = 1'b1;
  endtask

  task automatic clear_store();
    w = 1'b0; h = 1'b0; b = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d; model_mem[a] = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic drain_wait(input string tag);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) cycle();
    chk(tag, exp_q.size(), 0);
    cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    ld_valid = 1'b0; ld_addr = '0; saw_full = 1'b0;
    clear_store();
    @(posedge clk); #1;
    for (int i = 0; i < NW; i++) begin
      pre_we = 1'b1; pre_addr = 8'(i); pre_data = $urandom(); model_mem[i] = pre_data;
      @(posedge clk); #1;
    end
    pre_we = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    chk("rst_ram_ena", s_ena, 0);
    chk("rst_drain", s_drain, 0);
    chk("rst_ready", s_ready, 1);
    chk("rst_empty", s_empty, 1);

    // full-word store: single write one cycle later
    set_store(1, 0, 0, 32'h10, 32'hDEADBEEF);
    cycle();
    chk("sw_n_ena", s_ena, 0);
    clear_store();
    cycle();
    chk("sw_n1_ena", s_ena, 1);
    chk("sw_n1_wena", s_wena, 1);
    chk("sw_n1_addr", s_addr, 4);
    chk("sw_n1_wdata", s_wdata, 32'hDEADBEEF);
    cycle();
    chk("sw_n2_ena", s_ena, 0);

    // byte store: READ at +1, WRITE at +3
    preload(8'd4, 32'h11223344);
    set_store(0, 0, 1, 32'h12, 32'h000000AB);
    cycle();
    clear_store();
    cycle();
    chk("sb_read_ena", s_ena, 1);
    chk("sb_read_wena", s_wena, 0);
    chk("sb_read_addr", s_addr, 4);
    cycle();
    chk("sb_merge_ena", s_ena, 0);
    chk("sb_merge_drain", s_drain, 1);
    cycle();
    chk("sb_write_wena", s_wena, 1);
    chk("sb_write_data", s_wdata, 32'h11AB3344);
    cycle();

    // halfword store to the upper half
    preload(8'd5, 32'hFFFFFFFF);
    set_store(0, 1, 0, 32'h16, 32'h00005566);
    cycle();
    clear_store();
    cycle(); cycle(); cycle();
    chk("sh_write_wena", s_wena, 1);
    chk("sh_write_data", s_wdata, 32'h5566FFFF);
    cycle();

    // misaligned and no-select requests are dropped
    set_store(1, 0, 0, 32'h11, 32'h12345678);
    cycle();
    chk("sw_misaligned_err", s_err, 1);
    set_store(0, 1, 0, 32'h13, 32'h00001234);
    cycle();
    chk("sh_misaligned_err", s_err, 1);
    set_store(0, 0, 0, 32'h20, 32'h00000099);
    cycle();
    chk("nosel_err", s_err, 1);
    clear_store();
    cycle();
    chk("misaligned_no_ram", s_ena, 0);
    chk("misaligned_empty", s_empty, 1);

    // back-to-back byte stores until the queue fills
    for (int k = 0; k < 6; k++) begin
      int tries;
      tries = 0;
      set_store(0, 0, 1, 32'h40 + 32'(4 * k + (k % 4)), 32'(k + 1));
      s_acc = 1'b0;
      while (!s_acc && tries < 20) begin
        cycle();
        tries++;
      end
      chk("fill_accept", s_acc, 1);
    end
    clear_store();
    chk("fill_saw_full", saw_full, 1);
    drain_wait("fill_drain");

    // load hazard against a pending byte store
    ld_valid = 1'b1; ld_addr = 32'h23;
    set_store(0, 0, 1, 32'h20, 32'h0000005A);
    cycle();
    chk("hz_same_cycle", s_hz, 0);
    clear_store();
    cycle();
    chk("hz_read", s_hz, 1);
    cycle();
    chk("hz_merge", s_hz, 1);
    cycle();
    chk("hz_write", s_hz, 1);
    cycle();
    chk("hz_after", s_hz, 0);
    ld_addr = 32'h24;
    set_store(0, 0, 1, 32'h20, 32'h000000A5);
    cycle();
    clear_store();
    cycle();
    chk("hz_other_word", s_hz, 0);
    ld_valid = 1'b0;
    drain_wait("hz_drain");

    // reset while the RMW is in MERGE
    preload(8'h30, 32'hCAFEF00D);
    set_store(0, 0, 1, 32'hC1, 32'h00000077);
    cycle();
    clear_store();
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_mid_state", s_state, 2);
    rst = 1'b0;
    cycle();
    chk("rst_mid_ena", s_ena, 0);
    chk("rst_mid_empty", s_empty, 1);
    chk("rst_mid_drain", s_drain, 0);
    cycle();
    chk("rst_mid_ram", mem[8'h30], 32'hCAFEF00D);

    // randomized traffic over a few words to provoke hazards and full queues
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = $urandom_range(0, 4);
      if (sel == 0) clear_store();
      else set_store(sel == 1, sel == 2, sel == 3,
                     32'h80 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
                     $urandom());
      ld_valid = 1'($urandom_range(0, 1));
      ld_addr  = 32'h80 + 32'($urandom_range(0, 31));
      rst      = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0; clear_store(); ld_valid = 1'b0;
    drain_wait("rand_drain");

    // final memory image against the model
    for (int i = 0; i < NW; i++) chk($sformatf("mem_final[%0d]", i), mem[i], model_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_store_buf.md
Name: pipe_store_buf

Overview:
- Store-side counterpart of the MEM-stage load path: accepts sw/sh/sb requests from the MEM stage, checks alignment, and queues them in a small FIFO.
- Drains queued stores into the word-wide data RAM. That RAM has no byte enables, so sub-word stores use read-modify-write (RMW).
- Flags loads that hit a pending store word so the pipeline can stall.
- Owns the data RAM port while draining; the load path is gated by drain_active.

Parameters:
- DEPTH, 4, store queue entries (power of two, ≥2)
- ADDR_W, 8, RAM word-address width; uses addr[ADDR_W+1:2]

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- w  in  1  word store select
- h  in  1  halfword store select
- b  in  1  byte store select
- st_valid  in  1  store request this cycle
- addr  in  32  store byte address
- st_data  in  32  store data, right-justified
- st_ready  out  1  queue can accept (= ~full)
- AddressErr  out  1  current request misaligned or has no size select
- ld_valid  in  1  MEM-stage load present
- ld_addr  in  32  load byte address
- ld_hazard  out  1  load word matches a pending store
- drain_active  out  1  block owns the RAM port this cycle
- empty  out  1  queue empty and FSM idle
- ram_ena  out  1  RAM enable
- ram_wena  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid one cycle after a read-enable cycle

Behaviour:
- AddressErr (combinational): ~((w & addr[1:0]==0) | (h & ~addr[0]) | b). With w=h=b=0 it is 1. More than one select set: priority w>h>b.
- Enqueue: on st_valid & st_ready & ~AddressErr. Errored or not-ready requests are dropped; the upstream stalls on ~st_ready.
- Entry fields: word address, lane mask[3:0], lane-replicated data.
  - b: mask = 1<<addr[1:0]; data = {4{st_data[7:0]}}
  - h: mask = addr[1] ? 4'b1100 : 4'b0011; data = {2{st_data[15:0]}}
  - w: mask = 4'b1111; data = st_data
- Queue: circular buffer with rd/wr pointers and a count. st_ready depends only on count, so there is no same-cycle bypass when full. Enqueue and dequeue in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, READ, MERGE, WRITE.
  - IDLE: if not empty, check the head entry mask. Mask 4'b1111 goes to WRITE; any other mask goes to READ.
  - READ: ram_ena=1, ram_wena=0, ram_addr=head address → MERGE.
  - MERGE: latch merged = per lane, mask ? entry data : ram_rdata → WRITE. RAM is idle this cycle.
  - WRITE: ram_ena=1, ram_wena=1, ram_wdata = merged (or entry data if full word); pop head → IDLE.
- Latency for an isolated sub-word store: enqueue at cycle N, READ at N+1, write at N+3. Full word: write at N+1.
- drain_active = 1 in READ, MERGE and WRITE.
- ld_hazard = ld_valid & any valid entry (including the head being drained) with word address == ld_addr[ADDR_W+1:2]. A store enqueued in the same cycle is not included.
- Reset (any cycle, including mid-RMW): count, pointers → 0; FSM → IDLE; ram_ena, ram_wena, drain_active, ld_hazard → 0 from the next cycle; st_ready=1; empty=1. An abandoned RMW leaves RAM unmodified, because the write is a single cycle.
- ram_addr and ram_wdata are don't-care when ram_ena=0 and are driven 0.

Decomposition:
- Shared package holds:
  - FSM state encodings (2-bit: IDLE=0, READ=1, MERGE=2, WRITE=3)
  - lane-mask constants (MASK_W=4'b1111, MASK_HLO=4'b0011, MASK_HHI=4'b1100)
- One sub-module, store_align: combinational size/addr → mask, replicated data, AddressErr. It is reusable by the load path.
- The FIFO and FSM stay in the top module.

Test Plan:
- Reset, then sw addr=0x10 data=0xDEADBEEF → one write cycle at +1: ram_addr=4, ram_wdata=0xDEADBEEF, no read issued.
- RAM word 4 = 0x11223344; sb addr=0x12 data=0xAB → READ at +1, WRITE at +3 with ram_wdata=0x11AB3344.
- sh addr=0x16 data=0x5566 over word 5 = 0xFFFFFFFF → ram_wdata=0x5566FFFF.
- Misaligned: sw addr=0x11 and sh addr=0x13 → AddressErr=1, no enqueue, no RAM activity. With w=h=b=0 → AddressErr=1.
- Fill with DEPTH sb stores while the RAM is stalled → st_ready=0 after the 4th. A 5th request is held off; drain proceeds in order; st_ready returns the cycle after the first pop.
- Pending sb to addr 0x20; ld_addr=0x23 ld_valid=1 → ld_hazard=1 until that store's WRITE cycle completes. ld_addr=0x24 → ld_hazard=0.
- Assert rst during MERGE → next cycle ram_ena=0, empty=1, RAM word unchanged.
